// File: rtl/dot_prod_feeder.sv
// Operand supplier for dot_prod: a weight column store plus a ping-pong input
// vector buffer. The shadow bank fills while the active bank is read; banks swap at a pass boundary.
module dot_prod_feeder #(
  parameter int NROW          = 16,
  parameter int NCOL          = 16,
  parameter int QN            = 6,
  parameter int QM            = 11,
  parameter int BITWIDTH      = QN + QM + 1,
  parameter int ADDR_BITWIDTH = $clog2(NCOL)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wrEn,
  input  logic [ADDR_BITWIDTH-1:0]   wrAddr,
  input  logic [NROW*BITWIDTH-1:0]   wrData,
  input  logic                       inValid,
  input  logic [BITWIDTH-1:0]        inData,
  output logic                       inReady,
  input  logic [ADDR_BITWIDTH-1:0]   colAddress,
  input  logic                       dataReady,
  output logic [NROW*BITWIDTH-1:0]   weightRow,
  output logic [BITWIDTH-1:0]        inputVector,
  output logic                       vecValid,
  output logic                       swapPulse,
  output logic                       underrun
);

  logic [NCOL-1:0][NROW*BITWIDTH-1:0]  wmem_q;
  logic [1:0][NCOL-1:0][BITWIDTH-1:0]  bank_q;

  logic [ADDR_BITWIDTH-1:0] fillPtr_q, fillPtr_d;
  logic shadowFull_q, shadowFull_d;
  logic bankSel_q, bankSel_d;
  logic vecValid_q, vecValid_d;
  logic swapPulse_q, underrun_q;
  logic drPrev_q;

  logic accept, drRise, swap, undr;

  assign accept = inValid & ~shadowFull_q;
  assign drRise = dataReady & ~drPrev_q;
  // An empty active bank takes the first full vector without waiting for a pass end.
  assign swap   = shadowFull_q & (drRise | ~vecValid_q);
  assign undr   = drRise & vecValid_q & ~shadowFull_q;

  always_comb begin
    fillPtr_d    = fillPtr_q;
    shadowFull_d = shadowFull_q;
    bankSel_d    = bankSel_q;
    vecValid_d   = vecValid_q;
    if (accept) begin
      fillPtr_d = fillPtr_q + 1'b1;
      if (fillPtr_q == ADDR_BITWIDTH'(NCOL-1)) shadowFull_d = 1'b1;
    end
    if (swap) begin
      bankSel_d    = ~bankSel_q;
      shadowFull_d = 1'b0;
      vecValid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fillPtr_q    <= '0;
      shadowFull_q <= 1'b0;
      bankSel_q    <= 1'b0;
      vecValid_q   <= 1'b0;
      swapPulse_q  <= 1'b0;
      underrun_q   <= 1'b0;
      drPrev_q     <= 1'b0;
    end else begin
      fillPtr_q    <= fillPtr_d;
      shadowFull_q <= shadowFull_d;
      bankSel_q    <= bankSel_d;
      vecValid_q   <= vecValid_d;
      swapPulse_q  <= swap;
      underrun_q   <= undr;
      drPrev_q     <= dataReady;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wmem_q <= '0;
    end else if (wrEn) begin
      wmem_q[wrAddr] <= wrData;
    end
  end

  // The shadow bank is always the one not selected for reading.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q <= '0;
    end else if (accept) begin
      bank_q[~bankSel_q][fillPtr_q] <= inData;
    end
  end

  assign inReady     = ~shadowFull_q;
  assign weightRow   = wmem_q[colAddress];
  assign inputVector = bank_q[bankSel_q][colAddress];
  assign vecValid    = vecValid_q;
  assign swapPulse   = swapPulse_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Scoreboard bench for dot_prod_feeder: a queue-based reference model predicts
// accepts, swaps and underruns; a negedge monitor compares every visible output.
module tb_dot_prod_feeder;
  localparam int NROW = 16, NCOL = 16, QN = 6, QM = 11;
  localparam int BW = QN + QM + 1;
  localparam int AW = $clog2(NCOL);
  localparam int WW = NROW * BW;

  typedef logic [NCOL*BW-1:0] vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wrEn = 1'b0;
  logic [AW-1:0] wrAddr = '0;
  logic [WW-1:0] wrData = '0;
  logic          inValid = 1'b0;
  logic [BW-1:0] inData = '0;
  logic          inReady;
  logic [AW-1:0] colAddress = '0;
  logic          dataReady = 1'b0;
  logic [WW-1:0] weightRow;
  logic [BW-1:0] inputVector;
  logic          vecValid, swapPulse, underrun;

  dot_prod_feeder #(.NROW(NROW), .NCOL(NCOL), .QN(QN), .QM(QM)) dut (
    .clk(clk), .reset(reset), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .inValid(inValid), .inData(inData), .inReady(inReady),
    .colAddress(colAddress), .dataReady(dataReady), .weightRow(weightRow),
    .inputVector(inputVector), .vecValid(vecValid), .swapPulse(swapPulse),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_swaps = 0;
  int n_under = 0;

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: vectors as queues/arrays, events as plain booleans.
  logic [WW-1:0] m_w   [NCOL];
  logic [BW-1:0] m_act [NCOL];
  logic [BW-1:0] m_sh  [$];
  bit            m_valid, m_drprev, m_swap, m_under;
  vec_t          exp_q [$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (m_w[i])   m_w[i] = '0;
      foreach (m_act[i]) m_act[i] = '0;
      m_sh.delete();
      exp_q.delete();
      m_valid = 0; m_drprev = 0; m_swap = 0; m_under = 0;
    end else begin
      bit rise, full, sw, un;
      vec_t v;
      rise = dataReady && !m_drprev;
      full = (m_sh.size() == NCOL);
      sw   = full && (rise || !m_valid);
      un   = rise && m_valid && !full;
      if (wrEn) m_w[wrAddr] = wrData;
      if (inValid && !full) m_sh.push_back(inData);
      if (sw) begin
        for (int i = 0; i < NCOL; i++) begin
          m_act[i] = m_sh[i];
          v[i*BW +: BW] = m_sh[i];
        end
        m_sh.delete();
        m_valid = 1;
        exp_q.push_back(v);
      end
      m_swap = sw; m_under = un; m_drprev = dataReady;
    end
  end

  // Monitor: sampled on the falling edge, away from state updates.
  always @(negedge clk) begin
    chk("inReady",     WW'(inReady),     WW'(m_sh.size() < NCOL));
    chk("vecValid",    WW'(vecValid),    WW'(m_valid));
    chk("swapPulse",   WW'(swapPulse),   WW'(m_swap));
    chk("underrun",    WW'(underrun),    WW'(m_under));
    chk("weightRow",   weightRow,        m_w[colAddress]);
    chk("inputVector", WW'(inputVector), WW'(m_act[colAddress]));
    if (underrun) n_under++;
    if (swapPulse) begin
      n_swaps++;
      if (exp_q.size() == 0) begin
        chk("swap_unexpected", WW'(1), WW'(0));
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        chk("swap_vector", WW'(inputVector), WW'(e[colAddress*BW +: BW]));
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic stream(input int first, input int count);
    for (int v = first; v < first + count; v++) begin
      inValid = 1'b1;
      inData  = BW'(v << QM);
      step();
    end
    inValid = 1'b0;
  endtask

  task automatic pulse_dr();
    dataReady = 1'b1; step();
    dataReady = 1'b0; step();
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    step(2);

    // Column k holds k in every row.
    for (int k = 0; k < NCOL; k++) begin
      wrEn = 1'b1; wrAddr = AW'(k);
      for (int r = 0; r < NROW; r++) wrData[r*BW +: BW] = BW'(k);
      step();
    end
    wrEn = 1'b0;
    stream(1, NCOL);
    colAddress = AW'(3);
    step(3);
    chk("vec_at3", WW'(inputVector), WW'(4 << QM));

    // New vector behind a running pass, then swap on the pass boundary.
    stream(17, NCOL);
    step(2);
    pulse_dr();
    colAddress = '0;
    step();
    chk("vec_at0_after_swap", WW'(inputVector), WW'(17 << QM));

    // Half-filled shadow at pass end: underrun, then completion and swap.
    stream(40, 8);
    pulse_dr();
    step(2);
    stream(48, 8);
    step(2);
    pulse_dr();
    step(2);

    // Reset mid-fill discards the partial vector.
    stream(60, 7);
    reset = 1'b1; step();
    reset = 1'b0; step();
    stream(100, NCOL);
    step(3);

    // Last element on the same edge as the pass boundary.
    stream(200, NCOL - 1);
    inValid = 1'b1; inData = BW'(7); dataReady = 1'b1; step();
    inValid = 1'b0; dataReady = 1'b0; step(2);
    pulse_dr();
    step(2);

    for (int c = 0; c < 4000; c++) begin
      inValid    = ($urandom_range(0, 3) != 0);
      inData     = BW'($urandom);
      wrEn       = ($urandom_range(0, 7) == 0);
      wrAddr     = AW'($urandom);
      for (int r = 0; r < NROW; r++) wrData[r*BW +: BW] = BW'($urandom);
      colAddress = AW'($urandom);
      if ($urandom_range(0, 9) == 0) dataReady = ~dataReady;
      reset      = ($urandom_range(0, 799) == 0);
      step();
    end
    reset = 1'b0; inValid = 1'b0; wrEn = 1'b0; dataReady = 1'b0;
    step(4);
    chk("scoreboard_drained", WW'(exp_q.size()), WW'(0));
    chk("saw_swaps",    WW'(n_swaps > 3), WW'(1));
    chk("saw_underrun", WW'(n_under > 0), WW'(1));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
